// File: rtl/vx_mem_port_arbiter.sv
// vx_mem_port_arbiter: round-robin core/host arbiter in front of one memory port,
// with tag-routed responses, per-source read credit counters and core quiesce.
module vx_mem_port_arbiter #(
    parameter int ADDR_WIDTH   = 26,
    parameter int DATA_WIDTH   = 512,
    parameter int BYTEEN_WIDTH = 64,
    parameter int TAG_WIDTH    = 8,
    parameter int CNT_WIDTH    = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    core_req_valid,
    input  logic                    core_req_rw,
    input  logic [BYTEEN_WIDTH-1:0] core_req_byteen,
    input  logic [ADDR_WIDTH-1:0]   core_req_addr,
    input  logic [DATA_WIDTH-1:0]   core_req_data,
    input  logic [TAG_WIDTH-1:0]    core_req_tag,
    output logic                    core_req_ready,
    input  logic                    host_req_valid,
    input  logic                    host_req_rw,
    input  logic [BYTEEN_WIDTH-1:0] host_req_byteen,
    input  logic [ADDR_WIDTH-1:0]   host_req_addr,
    input  logic [DATA_WIDTH-1:0]   host_req_data,
    input  logic [TAG_WIDTH-1:0]    host_req_tag,
    output logic                    host_req_ready,
    output logic                    core_rsp_valid,
    output logic [DATA_WIDTH-1:0]   core_rsp_data,
    output logic [TAG_WIDTH-1:0]    core_rsp_tag,
    input  logic                    core_rsp_ready,
    output logic                    host_rsp_valid,
    output logic [DATA_WIDTH-1:0]   host_rsp_data,
    output logic [TAG_WIDTH-1:0]    host_rsp_tag,
    input  logic                    host_rsp_ready,
    output logic                    mem_req_valid,
    output logic                    mem_req_rw,
    output logic [BYTEEN_WIDTH-1:0] mem_req_byteen,
    output logic [ADDR_WIDTH-1:0]   mem_req_addr,
    output logic [DATA_WIDTH-1:0]   mem_req_data,
    output logic [TAG_WIDTH:0]      mem_req_tag,
    input  logic                    mem_req_ready,
    input  logic                    mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0]   mem_rsp_data,
    input  logic [TAG_WIDTH:0]      mem_rsp_tag,
    output logic                    mem_rsp_ready,
    input  logic                    core_hold,
    output logic                    core_quiesced,
    output logic                    rsp_orphan
);
    localparam logic [CNT_WIDTH:0] CNT_MAX = (CNT_WIDTH+1)'((1 << CNT_WIDTH) - 1);
    logic rr, rsp_src, rsp_fire, drain, can_load, core_elig, host_elig, win, grant, reg_core_next;
    logic [1:0] inc, dec, pend;
    logic [1:0][CNT_WIDTH-1:0] cnt, cnt_next;
    logic [1:0][CNT_WIDTH:0] used;
    assign drain    = mem_req_valid && mem_req_ready;
    assign can_load = !mem_req_valid || mem_req_ready;
    assign pend     = {2{mem_req_valid && !mem_req_rw}} & {mem_req_tag[TAG_WIDTH], !mem_req_tag[TAG_WIDTH]};
    assign inc      = {2{drain && !mem_req_rw}} & {mem_req_tag[TAG_WIDTH], !mem_req_tag[TAG_WIDTH]};
    assign rsp_src  = mem_rsp_tag[TAG_WIDTH];
    assign rsp_fire = mem_rsp_valid && mem_rsp_ready;
    assign dec      = {rsp_fire && rsp_src, rsp_fire && !rsp_src};
    // A read parked in the output register already holds a credit, so the
    // counter can never be pushed past its maximum by the pipelined drain.
    always_comb begin
        for (int s = 0; s < 2; s++) begin
            used[s]     = {1'b0, cnt[s]} + {{CNT_WIDTH{1'b0}}, pend[s]};
            cnt_next[s] = cnt[s] + CNT_WIDTH'(inc[s]) - CNT_WIDTH'(dec[s] && cnt[s] != '0);
        end
    end
    assign core_elig      = core_req_valid && !core_hold && (core_req_rw || used[0] < CNT_MAX);
    assign host_elig      = host_req_valid && (host_req_rw || used[1] < CNT_MAX);
    assign win            = (core_elig && host_elig) ? rr : host_elig;
    assign grant          = (core_elig || host_elig) && can_load && !reset;
    assign core_req_ready = grant && !win;
    assign host_req_ready = grant && win;
    assign reg_core_next  = can_load ? (grant && !win) : (mem_req_valid && !mem_req_tag[TAG_WIDTH]);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_req_valid  <= 1'b0;
            mem_req_rw     <= 1'b0;
            mem_req_byteen <= '0;
            mem_req_addr   <= '0;
            mem_req_data   <= '0;
            mem_req_tag    <= '0;
            rr             <= 1'b0;
            cnt            <= '0;
            rsp_orphan     <= 1'b0;
            core_quiesced  <= 1'b0;
        end else begin
            if (can_load) begin
                mem_req_valid  <= grant;
                mem_req_rw     <= win ? host_req_rw : core_req_rw;
                mem_req_byteen <= win ? host_req_byteen : core_req_byteen;
                mem_req_addr   <= win ? host_req_addr : core_req_addr;
                mem_req_data   <= win ? host_req_data : core_req_data;
                mem_req_tag    <= win ? {1'b1, host_req_tag} : {1'b0, core_req_tag};
            end
            rr            <= grant ? !win : rr;
            cnt           <= cnt_next;
            rsp_orphan    <= rsp_orphan || |(dec & {cnt[1] == '0, cnt[0] == '0});
            core_quiesced <= core_hold && cnt_next[0] == '0 && !reg_core_next;
        end
    end
    assign mem_rsp_ready  = rsp_src ? host_rsp_ready : core_rsp_ready;
    assign core_rsp_valid = mem_rsp_valid && !rsp_src;
    assign host_rsp_valid = mem_rsp_valid && rsp_src;
    assign core_rsp_data  = mem_rsp_data;
    assign host_rsp_data  = mem_rsp_data;
    assign core_rsp_tag   = mem_rsp_tag[TAG_WIDTH-1:0];
    assign host_rsp_tag   = mem_rsp_tag[TAG_WIDTH-1:0];
endmodule

// File: tb/tb_vx_mem_port_arbiter.sv
// tb_vx_mem_port_arbiter: directed and randomized checks of the arbiter against
// a transaction-level model tracking in-flight reads per source as queues.
module tb_vx_mem_port_arbiter;
    localparam int AW = 26, DW = 32, BW = 4, TW = 8, CW = 2, MAXC = 3;
    logic clk = 0, reset = 1;
    logic core_req_valid, core_req_rw, core_req_ready, host_req_valid, host_req_rw, host_req_ready;
    logic [BW-1:0] core_req_byteen, host_req_byteen, mem_req_byteen;
    logic [AW-1:0] core_req_addr, host_req_addr, mem_req_addr;
    logic [DW-1:0] core_req_data, host_req_data, mem_req_data, core_rsp_data, host_rsp_data, mem_rsp_data;
    logic [TW-1:0] core_req_tag, host_req_tag, core_rsp_tag, host_rsp_tag;
    logic core_rsp_valid, core_rsp_ready, host_rsp_valid, host_rsp_ready;
    logic mem_req_valid, mem_req_rw, mem_req_ready, mem_rsp_valid, mem_rsp_ready;
    logic [TW:0] mem_req_tag, mem_rsp_tag;
    logic core_hold, core_quiesced, rsp_orphan;

    vx_mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTEEN_WIDTH(BW), .TAG_WIDTH(TW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset),
        .core_req_valid(core_req_valid), .core_req_rw(core_req_rw), .core_req_byteen(core_req_byteen),
        .core_req_addr(core_req_addr), .core_req_data(core_req_data), .core_req_tag(core_req_tag),
        .core_req_ready(core_req_ready),
        .host_req_valid(host_req_valid), .host_req_rw(host_req_rw), .host_req_byteen(host_req_byteen),
        .host_req_addr(host_req_addr), .host_req_data(host_req_data), .host_req_tag(host_req_tag),
        .host_req_ready(host_req_ready),
        .core_rsp_valid(core_rsp_valid), .core_rsp_data(core_rsp_data), .core_rsp_tag(core_rsp_tag),
        .core_rsp_ready(core_rsp_ready),
        .host_rsp_valid(host_rsp_valid), .host_rsp_data(host_rsp_data), .host_rsp_tag(host_rsp_tag),
        .host_rsp_ready(host_rsp_ready),
        .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw), .mem_req_byteen(mem_req_byteen),
        .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data), .mem_req_tag(mem_req_tag),
        .mem_req_ready(mem_req_ready),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .mem_rsp_tag(mem_rsp_tag),
        .mem_rsp_ready(mem_rsp_ready),
        .core_hold(core_hold), .core_quiesced(core_quiesced), .rsp_orphan(rsp_orphan)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic          rw;
        logic [BW-1:0] be;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [TW:0]   tag;
    } req_t;

    // model: request waiting downstream, reads in flight per source, arbitration preference
    req_t m_reg;
    logic m_valid = 0, m_rr = 0, m_orphan = 0, m_q = 0;
    logic [TW-1:0] flight0[$], flight1[$];

    function automatic int outstanding(input int s);
        int n = (s == 1) ? flight1.size() : flight0.size();
        if (m_valid && !m_reg.rw && int'(m_reg.tag[TW]) == s) n++;
        return n;
    endfunction

    function automatic void retire(input logic src, input logic [TW-1:0] t);
        int k = 0;
        if (src) begin
            for (int i = flight1.size() - 1; i >= 0; i--) if (flight1[i] == t) k = i;
            flight1.delete(k);
        end else begin
            for (int i = flight0.size() - 1; i >= 0; i--) if (flight0[i] == t) k = i;
            flight0.delete(k);
        end
    endfunction

    always @(negedge clk) begin : compare
        logic ce, he, w, can, g, s, hs;
        if (reset) begin
            m_valid = 0; m_rr = 0; m_orphan = 0; m_q = 0;
            flight0.delete(); flight1.delete();
        end
        ce  = core_req_valid && !core_hold && (core_req_rw || outstanding(0) < MAXC);
        he  = host_req_valid && (host_req_rw || outstanding(1) < MAXC);
        w   = (ce && he) ? m_rr : he;
        can = !m_valid || mem_req_ready;
        g   = (ce || he) && can && !reset;
        s   = mem_rsp_tag[TW];
        chk("core_req_ready", core_req_ready, g && !w);
        chk("host_req_ready", host_req_ready, g && w);
        chk("mem_req_valid", mem_req_valid, m_valid);
        if (m_valid) begin
            chk("mem_req_rw", mem_req_rw, m_reg.rw);
            chk("mem_req_byteen", mem_req_byteen, m_reg.be);
            chk("mem_req_addr", mem_req_addr, m_reg.addr);
            chk("mem_req_data", mem_req_data, m_reg.data);
            chk("mem_req_tag", mem_req_tag, m_reg.tag);
        end
        chk("core_rsp_valid", core_rsp_valid, mem_rsp_valid && !s);
        chk("host_rsp_valid", host_rsp_valid, mem_rsp_valid && s);
        chk("mem_rsp_ready", mem_rsp_ready, s ? host_rsp_ready : core_rsp_ready);
        chk("core_rsp_data", core_rsp_data, mem_rsp_data);
        chk("host_rsp_data", host_rsp_data, mem_rsp_data);
        chk("core_rsp_tag", core_rsp_tag, mem_rsp_tag[TW-1:0]);
        chk("host_rsp_tag", host_rsp_tag, mem_rsp_tag[TW-1:0]);
        chk("core_quiesced", core_quiesced, m_q);
        chk("rsp_orphan", rsp_orphan, m_orphan);
        if (!reset) begin
            hs = mem_rsp_valid && (s ? host_rsp_ready : core_rsp_ready);
            if (hs) begin
                if ((s ? flight1.size() : flight0.size()) == 0) m_orphan = 1;
                else retire(s, mem_rsp_tag[TW-1:0]);
            end
            if (m_valid && mem_req_ready && !m_reg.rw) begin
                if (m_reg.tag[TW]) flight1.push_back(m_reg.tag[TW-1:0]);
                else flight0.push_back(m_reg.tag[TW-1:0]);
            end
            if (can) begin
                m_valid = g;
                if (g) m_reg = w ? '{host_req_rw, host_req_byteen, host_req_addr, host_req_data, {1'b1, host_req_tag}}
                                 : '{core_req_rw, core_req_byteen, core_req_addr, core_req_data, {1'b0, core_req_tag}};
            end
            if (g) m_rr = !w;
            m_q = core_hold && flight0.size() == 0 && !(m_valid && !m_reg.tag[TW]);
        end
    end

    task automatic idle();
        core_req_valid = 0; core_req_rw = 0; core_req_byteen = '0; core_req_addr = '0; core_req_data = '0; core_req_tag = '0;
        host_req_valid = 0; host_req_rw = 0; host_req_byteen = '0; host_req_addr = '0; host_req_data = '0; host_req_tag = '0;
        core_rsp_ready = 0; host_rsp_ready = 0; mem_req_ready = 1;
        mem_rsp_valid = 0; mem_rsp_data = '0; mem_rsp_tag = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
        #1;
    endtask

    task automatic rand_stim();
        logic src;
        int idx;
        core_req_valid = ($urandom % 4) != 0; core_req_rw = ($urandom % 3) == 0;
        core_req_byteen = BW'($urandom); core_req_addr = AW'($urandom); core_req_data = $urandom; core_req_tag = TW'($urandom);
        host_req_valid = ($urandom % 3) == 0; host_req_rw = ($urandom % 2) == 0;
        host_req_byteen = BW'($urandom); host_req_addr = AW'($urandom); host_req_data = $urandom; host_req_tag = TW'($urandom);
        mem_req_ready = ($urandom % 4) != 0;
        core_rsp_ready = ($urandom % 5) != 0; host_rsp_ready = ($urandom % 5) != 0;
        if ($urandom % 16 == 0) core_hold = !core_hold;
        mem_rsp_data = $urandom;
        if ((flight0.size() + flight1.size()) > 0 && ($urandom % 2) == 0) begin
            src = flight0.size() == 0 ? 1'b1 : flight1.size() == 0 ? 1'b0 : 1'($urandom % 2);
            idx = src ? $urandom_range(flight1.size() - 1) : $urandom_range(flight0.size() - 1);
            mem_rsp_tag = {src, src ? flight1[idx] : flight0[idx]};
            mem_rsp_valid = 1;
        end else begin
            mem_rsp_valid = 0;
            mem_rsp_tag = (TW+1)'($urandom);
        end
    endtask

    initial begin
        int nc, nh;
        idle();
        core_hold = 0;
        core_req_valid = 1; host_req_valid = 1; host_req_rw = 1; core_req_rw = 1;
        at_neg();
        chk("reset_core_ready", core_req_ready, 0);
        chk("reset_host_ready", host_req_ready, 0);
        chk("reset_mem_valid", mem_req_valid, 0);
        chk("reset_mem_tag", mem_req_tag, 0);
        chk("reset_mem_addr", mem_req_addr, 0);
        chk("reset_orphan", rsp_orphan, 0);
        tick(); tick();
        reset = 0;

        // contention: continuous writes from both sides
        idle();
        core_req_valid = 1; core_req_rw = 1; core_req_addr = 26'h0000111;
        host_req_valid = 1; host_req_rw = 1; host_req_addr = 26'h0000222;
        nc = 0; nh = 0;
        for (int i = 0; i < 6; i++) begin
            at_neg();
            chk("cont_core_ready", core_req_ready, (i % 2) == 0);
            chk("cont_host_ready", host_req_ready, (i % 2) == 1);
            nc += int'(core_req_ready); nh += int'(host_req_ready);
            tick();
        end
        chk("cont_core_grants", nc, 3);
        chk("cont_host_grants", nh, 3);
        idle(); tick();

        // single core read and its response
        core_req_valid = 1; core_req_addr = 26'h2000000; core_req_tag = 8'h05;
        at_neg();
        chk("single_core_ready", core_req_ready, 1);
        tick();
        idle();
        at_neg();
        chk("single_mem_valid", mem_req_valid, 1);
        chk("single_mem_tag", mem_req_tag, 9'h005);
        chk("single_mem_addr", mem_req_addr, 26'h2000000);
        tick();
        mem_rsp_valid = 1; mem_rsp_tag = 9'h005; mem_rsp_data = 32'hDEADBEEF; core_rsp_ready = 1;
        at_neg();
        chk("single_rsp_valid", core_rsp_valid, 1);
        chk("single_rsp_tag", core_rsp_tag, 8'h05);
        chk("single_rsp_data", core_rsp_data, 32'hDEADBEEF);
        chk("single_rsp_host", host_rsp_valid, 0);
        tick();
        idle();
        at_neg();
        chk("single_no_orphan", rsp_orphan, 0);
        tick();

        // backpressure: host is preferred now
        core_req_valid = 1; core_req_rw = 1; core_req_addr = 26'h0000CCC;
        host_req_valid = 1; host_req_rw = 1; host_req_addr = 26'h0000AAA;
        mem_req_ready = 0;
        at_neg();
        chk("bp_host_grant", host_req_ready, 1);
        tick();
        for (int i = 0; i < 5; i++) begin
            at_neg();
            chk("bp_hold_valid", mem_req_valid, 1);
            chk("bp_hold_addr", mem_req_addr, 26'h0000AAA);
            chk("bp_core_ready", core_req_ready, 0);
            chk("bp_host_ready", host_req_ready, 0);
            tick();
        end
        mem_req_ready = 1;
        at_neg();
        chk("bp_drain_core_ready", core_req_ready, 1);
        tick();
        idle();
        at_neg();
        chk("bp_next_valid", mem_req_valid, 1);
        chk("bp_next_addr", mem_req_addr, 26'h0000CCC);
        tick();
        tick();

        // credit limit: three reads fit, fourth waits
        for (int i = 0; i < 5; i++) begin
            core_req_valid = 1; core_req_rw = 0; core_req_tag = TW'(i);
            at_neg();
            chk("credit_ready", core_req_ready, i < 3);
            tick();
        end
        core_req_rw = 1;
        at_neg();
        chk("credit_write_ok", core_req_ready, 1);
        tick();
        core_req_rw = 0; core_req_tag = 8'h03;
        mem_rsp_valid = 1; mem_rsp_tag = 9'h000; core_rsp_ready = 1;
        at_neg();
        chk("credit_still_blocked", core_req_ready, 0);
        tick();
        mem_rsp_valid = 0;
        at_neg();
        chk("credit_freed", core_req_ready, 1);
        tick();
        idle(); tick();
        mem_rsp_valid = 1; mem_rsp_tag = 9'h001; core_rsp_ready = 1;
        tick();

        // quiesce with two core reads outstanding
        idle();
        core_hold = 1; core_req_valid = 1; host_req_valid = 1; host_req_rw = 1;
        for (int i = 0; i < 3; i++) begin
            at_neg();
            chk("hold_core_ready", core_req_ready, 0);
            chk("hold_host_ready", host_req_ready, 1);
            chk("hold_quiesced_low", core_quiesced, 0);
            tick();
        end
        mem_rsp_valid = 1; mem_rsp_tag = 9'h002; core_rsp_ready = 1;
        at_neg(); tick();
        mem_rsp_tag = 9'h003;
        at_neg();
        chk("hold_quiesced_before", core_quiesced, 0);
        tick();
        mem_rsp_valid = 0;
        at_neg();
        chk("hold_quiesced_after", core_quiesced, 1);
        tick();
        core_hold = 0;
        idle(); tick();

        // orphan response to host
        mem_rsp_valid = 1; mem_rsp_tag = 9'h1FF; host_rsp_ready = 1;
        at_neg();
        chk("orphan_host_valid", host_rsp_valid, 1);
        chk("orphan_host_tag", host_rsp_tag, 8'hFF);
        chk("orphan_before", rsp_orphan, 0);
        tick();
        idle();
        for (int i = 0; i < 2; i++) begin
            at_neg();
            chk("orphan_sticky", rsp_orphan, 1);
            tick();
        end

        // reset in the middle of random traffic
        for (int i = 0; i < 20; i++) begin
            rand_stim();
            tick();
        end
        reset = 1;
        at_neg();
        chk("midreset_mem_valid", mem_req_valid, 0);
        chk("midreset_mem_tag", mem_req_tag, 0);
        chk("midreset_core_ready", core_req_ready, 0);
        chk("midreset_host_ready", host_req_ready, 0);
        chk("midreset_orphan", rsp_orphan, 0);
        chk("midreset_quiesced", core_quiesced, 0);
        tick();
        reset = 0;
        core_hold = 0;

        for (int i = 0; i < 3000; i++) begin
            rand_stim();
            tick();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/vx_mem_port_arbiter.md
# vx_mem_port_arbiter

- Two-requester arbiter in front of the single Vortex memory-slave port.
- Requester 0 is the Vortex core memory interface; requester 1 is a host/debug port used for program load and memory dump.
- Requests are arbitrated round-robin and registered once. The source ID is prepended to the tag, and responses are routed back by that tag bit.
- Per-source read-outstanding counters and a host-driven `core_hold` let the host quiesce the core before touching memory.

## Interface
Parameters:
- `ADDR_WIDTH`, default 26: memory word-address width.
- `DATA_WIDTH`, default 512: memory data width.
- `BYTEEN_WIDTH`, default 64: byte-enable width, DATA_WIDTH/8.
- `TAG_WIDTH`, default 8: requester tag width. The downstream tag is TAG_WIDTH+1.
- `CNT_WIDTH`, default 4: width of each outstanding-read counter. Maximum count is 2^CNT_WIDTH-1.

Ports. Clock and reset: one clock; reset is asynchronous and active-high.
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high reset.

Upstream request ports, x in {core, host}:
- `x_req_valid` in 1; `x_req_rw` in 1, where 1 = write.
- `x_req_byteen` in BYTEEN_WIDTH; `x_req_addr` in ADDR_WIDTH; `x_req_data` in DATA_WIDTH; `x_req_tag` in TAG_WIDTH.
- `x_req_ready` out 1.

Upstream response ports, x in {core, host}:
- `x_rsp_valid` out 1; `x_rsp_data` out DATA_WIDTH; `x_rsp_tag` out TAG_WIDTH.
- `x_rsp_ready` in 1.

Downstream request port:
- `mem_req_valid` out 1; `mem_req_rw` out 1; `mem_req_byteen` out BYTEEN_WIDTH; `mem_req_addr` out ADDR_WIDTH; `mem_req_data` out DATA_WIDTH.
- `mem_req_tag` out TAG_WIDTH+1, formatted as {src, tag}; src = 0 for core, 1 for host.
- `mem_req_ready` in 1.

Downstream response port:
- `mem_rsp_valid` in 1; `mem_rsp_data` in DATA_WIDTH; `mem_rsp_tag` in TAG_WIDTH+1.
- `mem_rsp_ready` out 1.

Control and status:
- `core_hold` in 1: block new core grants.
- `core_quiesced` out 1: high when `core_hold` is set, the core outstanding count is 0 and no core request sits in the output register.
- `rsp_orphan` out 1: sticky. Set by a response for a source whose outstanding count is 0.

## Operation
Output register:
- One entry: valid plus all request fields.
- Loads when empty, or when draining the same cycle (`mem_req_valid && mem_req_ready`).

Eligibility:
- Core is eligible when `core_req_valid && !core_hold`, and it is not a read while core count is at max.
- Host is eligible when `host_req_valid`, and it is not a read while host count is at max.

Arbitration:
- Pointer `rr` starts at 0 and names the preferred source.
- If both sources are eligible, `rr` wins; otherwise the sole eligible source wins.
- On a grant, `rr` becomes the other source. `rr` is unchanged when there is no grant.

Ready and load:
- `x_req_ready` = (winner == x) && register can load. This is combinational; ready never asserts for an ineligible source.
- On a grant, the register captures the winner's fields with tag {src, x_req_tag}.

Counters:
- cnt[src] increments when a read (rw=0) downstream handshake occurs.
- cnt[src] decrements when a response handshake (`mem_rsp_valid && mem_rsp_ready`) occurs for src = `mem_rsp_tag[TAG_WIDTH]`.
- Simultaneous increment and decrement on the same src leaves the count unchanged.
- A decrement at 0 is suppressed and sets `rsp_orphan`.
- Writes never touch the counters; they produce no response.

Response path (purely combinational, no storage):
- src = `mem_rsp_tag[TAG_WIDTH]`.
- `x_rsp_valid` = `mem_rsp_valid` && src == x.
- `x_rsp_data` = `mem_rsp_data`; `x_rsp_tag` = `mem_rsp_tag[TAG_WIDTH-1:0]`.
- `mem_rsp_ready` = the selected source's `x_rsp_ready`.

`core_hold` semantics:
- Never cancels a core request already in the output register.
- Never drops a core response.

## Timing
- Reset values: register empty, `mem_req_valid` = 0, all request fields 0, `rr` = 0, counters 0, `rsp_orphan` = 0. While reset is held, both `x_req_ready` are 0.
- Request latency: upstream handshake in cycle N gives `mem_req_valid` from cycle N+1.
- Throughput: one request per cycle when `mem_req_ready` stays high.
- Output stability: while `mem_req_valid && !mem_req_ready`, all request outputs are held stable.
- Response latency: 0 cycles.
- `core_quiesced` timing: registered from the post-update state. It rises one cycle after the last core response handshake or core write drain, with `core_hold` high.
- Reset mid-operation: everything clears asynchronously. In-flight responses arriving after reset release set `rsp_orphan`.

## Test plan
- Single source: core read of addr 0x200_0000 with tag 0x5 and `mem_req_ready` = 1 -> `mem_req_valid` the next cycle with tag 0x005. Response with tag 0x005 -> `core_rsp_valid`, tag 0x5; core count goes 0→1→0.
- Contention: both sources issue a continuous valid stream for 6 cycles -> grants alternate C,H,C,H,C,H; each `x_req_ready` is high on exactly 3 cycles.
- Backpressure: `mem_req_ready` = 0 for 5 cycles with the register full -> outputs stable and both readies 0. Ready then rises -> the held request drains and the next grant follows with no gap.
- Credit limit: CNT_WIDTH = 2, core issues 4 reads, no responses -> 3 reads accepted and the 4th is blocked. One response -> 4th accepted the following cycle; core writes are still accepted while blocked.
- Quiesce: assert `core_hold` with 2 core reads outstanding -> no new core grants, host still granted. `core_quiesced` rises one cycle after the 2nd response.
- Orphan and reset: response with tag 0x1FF while host count is 0 -> `rsp_orphan` = 1, sticky. Assert `reset` mid-stream -> all outputs return to reset values.
